// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_pkg
// Purpose  : Shared definitions for the memory access unit: access-size
//            encodings, FSM state type and the default memory size.
// Revision : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    // Access size encodings carried on req_size (2'b11 is illegal)
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    // Default memory size in bytes (16 KB)
    localparam int unsigned MEM_BYTES_DFLT = 16384;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_RMW_READ = 3'd2,
        ST_WRITE    = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_align
// Purpose  : Combinational byte-lane steering for little-endian word memory.
//            Load path : extract byte/halfword from a read word and sign- or
//                        zero-extend it.
//            Store path: merge right-justified store data into the addressed
//                        lanes of an old word (whole word for word stores).
// Ports    : i_rd_word   - word read from memory
//            i_addr_lo   - byte offset within the word (addr[1:0])
//            i_size      - access size encoding
//            i_unsigned  - zero-extend loads when 1
//            i_wdata     - right-justified store data
//            o_load_data - extracted and extended load data
//            o_merged    - word to write back
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] i_rd_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged
);

    logic [4:0]  w_byte_sh;
    logic [4:0]  w_half_sh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Bit offset of the addressed byte / halfword lane
    assign w_byte_sh = {i_addr_lo, 3'b000};
    assign w_half_sh = {i_addr_lo[1], 4'b0000};

    assign w_byte = i_rd_word[w_byte_sh +: 8];
    assign w_half = i_rd_word[w_half_sh +: 16];

    always_comb begin
        o_load_data = i_rd_word;
        case (i_size)
            SIZE_B:  o_load_data = {{24{w_byte[7]  & ~i_unsigned}}, w_byte};
            SIZE_H:  o_load_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
            default: o_load_data = i_rd_word;
        endcase
    end

    // Lanes outside the addressed byte/halfword keep the value just read
    always_comb begin
        o_merged = i_rd_word;
        case (i_size)
            SIZE_B:  o_merged[w_byte_sh +: 8]  = i_wdata[7:0];
            SIZE_H:  o_merged[w_half_sh +: 16] = i_wdata[15:0];
            default: o_merged = i_wdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Single-outstanding load/store unit between the core and a 16 KB
//            word memory (combinational read, synchronous write). Converts
//            byte/halfword/word accesses into word-aligned memory cycles,
//            using read-modify-write for sub-word stores.
// Ports    : clk, resetn (async, active-low)
//            req_*  - request from core (valid/ready handshake)
//            rsp_*  - one-cycle response pulse with load data / error flag
//            mem_*  - word-aligned memory interface
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DFLT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic        mem_we
);

    localparam logic [31:0] c_mem_limit = 32'(MEM_BYTES);

    state_t      r_state;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_addr_lo;
    logic [31:0] r_wdata;
    logic [29:0] r_word_addr;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [31:0] r_mem_data_in;
    logic        r_mem_we;

    logic        w_req_err;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;

    // Request rejection: illegal size, misalignment or out of range
    always_comb begin
        w_req_err = 1'b0;
        case (req_size)
            SIZE_B:  w_req_err = 1'b0;
            SIZE_H:  w_req_err = req_addr[0];
            SIZE_W:  w_req_err = |req_addr[1:0];
            default: w_req_err = 1'b1;
        endcase
        if (req_addr >= c_mem_limit) begin
            w_req_err = 1'b1;
        end
    end

    mem_lane_align u_lane_align (
        .i_rd_word   (mem_data_out),
        .i_addr_lo   (r_addr_lo),
        .i_size      (r_size),
        .i_unsigned  (r_unsigned),
        .i_wdata     (r_wdata),
        .o_load_data (w_load_data),
        .o_merged    (w_merged)
    );

    // All outputs are registered; each is set on the edge entering the
    // state in which it must be valid, so mem_we is a clean flop that is
    // high only while in WRITE and drops at once on reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_size        <= SIZE_B;
            r_unsigned    <= 1'b0;
            r_addr_lo     <= 2'b00;
            r_wdata       <= 32'h0;
            r_word_addr   <= 30'h0;
            r_req_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= 32'h0;
            r_rsp_err     <= 1'b0;
            r_mem_data_in <= 32'h0;
            r_mem_we      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_size      <= req_size;
                        r_unsigned  <= req_unsigned;
                        r_addr_lo   <= req_addr[1:0];
                        r_wdata     <= req_wdata;
                        r_word_addr <= req_addr[31:2];
                        r_req_ready <= 1'b0;
                        if (w_req_err) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= 32'h0;
                        end else if (!req_we) begin
                            r_state <= ST_LOAD;
                        end else if (req_size == SIZE_W) begin
                            r_state       <= ST_WRITE;
                            r_mem_data_in <= req_wdata;
                            r_mem_we      <= 1'b1;
                        end else begin
                            r_state <= ST_RMW_READ;
                        end
                    end
                end
                ST_LOAD: begin
                    r_state     <= ST_RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= w_load_data;
                end
                ST_RMW_READ: begin
                    r_state       <= ST_WRITE;
                    r_mem_data_in <= w_merged;
                    r_mem_we      <= 1'b1;
                end
                ST_WRITE: begin
                    r_state     <= ST_RESP;
                    r_mem_we    <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= 32'h0;
                end
                ST_RESP: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= 32'h0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_mem_we    <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign mem_address = {r_word_addr, 2'b00};
    assign mem_data_in = r_mem_data_in;
    assign mem_we      = r_mem_we;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed self-checking bench for mem_access_unit with a
//            behavioural 16 KB word memory (combinational read, write on
//            the rising clock edge).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_we;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mem [0:4095] = '{default: 32'h0};

    always #5 clk = ~clk;

    assign mem_data_out = (mem_address < 32'd16384) ? mem[mem_address[13:2]] : 32'h0;

    always @(posedge clk) begin
        if (mem_we && mem_address < 32'd16384) begin
            mem[mem_address[13:2]] <= mem_data_in;
        end
    end

    mem_access_unit #(.MEM_BYTES(16384)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_we       (mem_we)
    );

    // One transaction; called just after a rising edge with the DUT idle.
    // lat is the response cycle relative to the accept cycle (-1 = none).
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output int we_cnt, output int we_first);
        int waited;
        lat = -1; rdata = 32'hx; err = 1'bx; we_cnt = 0; we_first = -1;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_we) begin
                we_cnt++;
                if (we_first < 0) we_first = k;
            end
            if (rsp_valid) begin
                lat = k; rdata = rsp_rdata; err = rsp_err;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b exp 1", req_ready); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); else n_pass++;
        n_checks++; if (rsp_rdata !== 32'h0) $display("FAIL reset_rsp_rdata: got %h exp 0", rsp_rdata); else n_pass++;
        n_checks++; if (rsp_err !== 1'b0) $display("FAIL reset_rsp_err: got %b exp 0", rsp_err); else n_pass++;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b exp 0", mem_we); else n_pass++;
        n_checks++; if (mem_address !== 32'h0) $display("FAIL reset_mem_address: got %h exp 0", mem_address); else n_pass++;
        n_checks++; if (mem_data_in !== 32'h0) $display("FAIL reset_mem_data_in: got %h exp 0", mem_data_in); else n_pass++;
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_word_store_load();
        int lat, wc, wf; logic [31:0] rd; logic er;
        issue(1'b1, SIZE_W, 1'b0, 32'h100, 32'hDEADBEEF, lat, rd, er, wc, wf);
        n_checks++; if (lat !== 2) $display("FAIL wstore_latency: got %0d exp 2", lat); else n_pass++;
        n_checks++; if (wc !== 1 || wf !== 1) $display("FAIL wstore_we_pulse: got count %0d first %0d exp 1/1", wc, wf); else n_pass++;
        n_checks++; if (er !== 1'b0 || rd !== 32'h0) $display("FAIL wstore_rsp: got err %b rdata %h exp 0/0", er, rd); else n_pass++;
        n_checks++; if (mem[12'h040] !== 32'hDEADBEEF) $display("FAIL wstore_mem: got %h exp deadbeef", mem[12'h040]); else n_pass++;
        issue(1'b0, SIZE_W, 1'b0, 32'h100, 32'h0, lat, rd, er, wc, wf);
        n_checks++; if (lat !== 2) $display("FAIL wload_latency: got %0d exp 2", lat); else n_pass++;
        n_checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) $display("FAIL wload_data: got %h err %b exp deadbeef/0", rd, er); else n_pass++;
        n_checks++; if (wc !== 0) $display("FAIL wload_no_we: got %0d exp 0", wc); else n_pass++;
    endtask

    task automatic test_subword_store();
        int lat, wc, wf; logic [31:0] rd; logic er;
        issue(1'b1, SIZE_W, 1'b0, 32'h104, 32'h11223344, lat, rd, er, wc, wf);
        issue(1'b1, SIZE_B, 1'b0, 32'h106, 32'h123456AA, lat, rd, er, wc, wf);
        n_checks++; if (lat !== 3) $display("FAIL bstore_latency: got %0d exp 3", lat); else n_pass++;
        n_checks++; if (wc !== 1 || wf !== 2) $display("FAIL bstore_we_pulse: got count %0d first %0d exp 1/2", wc, wf); else n_pass++;
        n_checks++; if (mem[12'h041] !== 32'h11AA3344) $display("FAIL bstore_mem: got %h exp 11aa3344", mem[12'h041]); else n_pass++;
        issue(1'b0, SIZE_W, 1'b0, 32'h104, 32'h0, lat, rd, er, wc, wf);
        n_checks++; if (rd !== 32'h11AA3344 || lat !== 2) $display("FAIL bstore_readback: got %h lat %0d exp 11aa3344/2", rd, lat); else n_pass++;
        issue(1'b1, SIZE_H, 1'b0, 32'h104, 32'hFFFFBEEF, lat, rd, er, wc, wf);
        n_checks++; if (mem[12'h041] !== 32'h11AABEEF || lat !== 3) $display("FAIL hstore_lo: got %h lat %0d exp 11aabeef/3", mem[12'h041], lat); else n_pass++;
        issue(1'b1, SIZE_H, 1'b0, 32'h106, 32'h00005566, lat, rd, er, wc, wf);
        n_checks++; if (mem[12'h041] !== 32'h5566BEEF || er !== 1'b0) $display("FAIL hstore_hi: got %h err %b exp 5566beef/0", mem[12'h041], er); else n_pass++;
    endtask

    task automatic test_extension();
        int lat, wc, wf; logic [31:0] rd; logic er;
        logic [1:0]  t_size [0:8] = '{SIZE_B, SIZE_B, SIZE_H, SIZE_H, SIZE_B, SIZE_B, SIZE_B, SIZE_H, SIZE_W};
        logic        t_uns  [0:8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] t_addr [0:8] = '{32'h10A, 32'h10A, 32'h10A, 32'h10A, 32'h108, 32'h10B, 32'h109, 32'h108, 32'h108};
        logic [31:0] t_exp  [0:8] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF, 32'h000080FF, 32'h00000001,
                                      32'hFFFFFF80, 32'h0000007F, 32'h00007F01, 32'h80FF7F01};
        issue(1'b1, SIZE_W, 1'b0, 32'h108, 32'h80FF7F01, lat, rd, er, wc, wf);
        for (int i = 0; i < 9; i++) begin
            issue(1'b0, t_size[i], t_uns[i], t_addr[i], 32'h0, lat, rd, er, wc, wf);
            n_checks++;
            if (rd !== t_exp[i] || er !== 1'b0 || lat !== 2)
                $display("FAIL ext_load_%0d: got %h err %b lat %0d exp %h/0/2", i, rd, er, lat, t_exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_errors();
        int lat, wc, wf; logic [31:0] rd; logic er;
        logic        e_we   [0:4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0]  e_size [0:4] = '{SIZE_H, SIZE_W, 2'b11, SIZE_W, SIZE_B};
        logic [31:0] e_addr [0:4] = '{32'h101, 32'h102, 32'h100, 32'h4000, 32'h4000};
        for (int i = 0; i < 5; i++) begin
            issue(e_we[i], e_size[i], 1'b0, e_addr[i], 32'h0BADF00D, lat, rd, er, wc, wf);
            n_checks++;
            if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || wc !== 0)
                $display("FAIL err_req_%0d: got lat %0d err %b rdata %h we %0d exp 1/1/0/0", i, lat, er, rd, wc);
            else n_pass++;
        end
        n_checks++; if (mem[12'h040] !== 32'hDEADBEEF) $display("FAIL err_no_write: got %h exp deadbeef", mem[12'h040]); else n_pass++;
        issue(1'b0, SIZE_W, 1'b0, 32'h3FFC, 32'h0, lat, rd, er, wc, wf);
        n_checks++; if (lat !== 2 || er !== 1'b0) $display("FAIL last_word_ok: got lat %0d err %b exp 2/0", lat, er); else n_pass++;
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; req_we = 1'b0; req_size = SIZE_W; req_unsigned = 1'b0;
        req_addr = 32'h100; req_wdata = 32'h0;
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) $display("FAIL b2b_accept_a: got %b exp 1", req_ready); else n_pass++;
        @(posedge clk); #1;
        req_size = SIZE_H; req_unsigned = 1'b1; req_addr = 32'h106; req_we = 1'b0;
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL b2b_busy_load: got ready %b rsp %b exp 0/0", req_ready, rsp_valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0)
            $display("FAIL b2b_rsp_a: got rsp %b rdata %h ready %b exp 1/deadbeef/0", rsp_valid, rsp_rdata, req_ready);
        else n_pass++;
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL b2b_accept_b: got ready %b rsp %b exp 1/0", req_ready, rsp_valid); else n_pass++;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h00005566 || rsp_err !== 1'b0)
            $display("FAIL b2b_rsp_b: got rsp %b rdata %h err %b exp 1/00005566/0", rsp_valid, rsp_rdata, rsp_err);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    // Resets the DUT while a byte store to 0x10D sits in the given cycle
    // after acceptance (1 = RMW_READ, 2 = WRITE).
    task automatic reset_during_rmw(input int cyc, input string tag);
        bit seen;
        req_valid = 1'b1; req_we = 1'b1; req_size = SIZE_B; req_unsigned = 1'b0;
        req_addr = 32'h10D; req_wdata = 32'h00000055;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (cyc) @(negedge clk);
        if (cyc == 2) begin
            n_checks++; if (mem_we !== 1'b1) $display("FAIL %s_in_write: got mem_we %b exp 1", tag, mem_we); else n_pass++;
        end
        resetn = 1'b0;
        #1;
        n_checks++;
        if (mem_we !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_address !== 32'h0 || mem_data_in !== 32'h0 || rsp_err !== 1'b0)
            $display("FAIL %s_async_outputs: got we %b ready %b rsp %b addr %h din %h exp 0/1/0/0/0", tag, mem_we, req_ready, rsp_valid, mem_address, mem_data_in);
        else n_pass++;
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid || mem_we) seen = 1'b1;
        end
        resetn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid || mem_we) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL %s_no_response: got activity %b exp 0", tag, seen); else n_pass++;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL %s_ready_after: got %b exp 1", tag, req_ready); else n_pass++;
        n_checks++; if (mem[12'h043] !== 32'hCAFEF00D) $display("FAIL %s_mem_unchanged: got %h exp cafef00d", tag, mem[12'h043]); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_rmw();
        int lat, wc, wf; logic [31:0] rd; logic er;
        issue(1'b1, SIZE_W, 1'b0, 32'h10C, 32'hCAFEF00D, lat, rd, er, wc, wf);
        reset_during_rmw(1, "rst_rmw_read");
        reset_during_rmw(2, "rst_write");
        issue(1'b0, SIZE_W, 1'b0, 32'h10C, 32'h0, lat, rd, er, wc, wf);
        n_checks++; if (rd !== 32'hCAFEF00D || lat !== 2) $display("FAIL rst_recover_load: got %h lat %0d exp cafef00d/2", rd, lat); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_subword_store();
        test_extension();
        test_errors();
        test_back_to_back();
        test_reset_mid_rmw();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no end exp finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator-side access unit between the processor core and the single-port 16 KB word memory, which has a combinational read and a synchronous write. It accepts one load or store request at a time from the core and converts byte, halfword and word accesses into word-aligned memory cycles. Sub-word stores use read-modify-write. Load data is returned extracted and sign- or zero-extended, together with an error flag for misaligned, out-of-range or illegal-size requests.

## Interface

Parameters:

- MEM_BYTES, 16384, memory size in bytes; accesses with addr >= MEM_BYTES are errors.

Ports (one clock; reset is asynchronous and active-low):

- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  request rejected; no memory write occurred.
- mem_address  out  32  byte address to memory, bits [1:0] forced to 0.
- mem_data_in  out  32  write word to memory.
- mem_data_out  in  32  read word from memory (combinational).
- mem_we  out  1  memory write enable.

## Operation

- States: IDLE, LOAD, RMW_READ, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch all req_* fields.
  - Error check: size 11, halfword with addr[0]=1, word with addr[1:0]!=0, or addr >= MEM_BYTES. Any error goes to RESP with rsp_err=1.
  - Otherwise: load goes to LOAD; word store goes to WRITE; byte or halfword store goes to RMW_READ.
- LOAD: drive mem_address, capture lane-extracted and extended mem_data_out, then go to RESP.
- RMW_READ: drive mem_address, capture mem_data_out merged with the store lanes, then go to WRITE.
- WRITE: mem_we=1 with mem_data_in equal to the merged word (full word for a word store), then go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then go to IDLE. req_ready=0 in this state.
- Lanes are little-endian: byte k occupies [8k+7:8k].
  - Halfword at addr[1]=1 occupies [31:16].
  - A byte store replaces only lane addr[1:0]; the other three bytes are preserved from the read.
- Extension: a signed byte replicates bit 7; a signed halfword replicates bit 15. Word loads ignore req_unsigned.
- req_valid in any state other than IDLE is ignored; the core must hold it until it sees req_ready.
- mem_we is decoded only from the WRITE state. It never glitches high in other states.

## Timing

- Latency is counted from T, the accept cycle (req_valid and req_ready both high). rsp_valid is high in:
  - T+1 for an error;
  - T+2 for a load or a word store;
  - T+3 for a sub-word store.
- The memory write takes effect at the rising edge that ends WRITE. A load issued in the following request reads the new data.
- Back-to-back: the next request can be accepted in the cycle after RESP (IDLE).
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; mem_we=0; mem_address=0; mem_data_in=0.
- Reset asserted mid-operation:
  - mem_we drops immediately (asynchronous);
  - no response is produced;
  - a partially completed read-modify-write leaves memory unmodified.

## Structure

- Package mem_access_pkg holds:
  - size encodings SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10;
  - the state enum;
  - the MEM_BYTES default.
- Sub-module mem_lane_align is purely combinational:
  - load path: extract and extend from (word, addr[1:0], size, unsigned);
  - store path: merge from (old word, wdata, addr[1:0], size).
- The top level contains the FSM, the request registers and the response registers.

## Test plan

- Word store then load: store addr 0x100, data 0xDEADBEEF. Expect mem_we for exactly one cycle at T+1 and rsp_valid at T+2. Load 0x100 must return 0xDEADBEEF, rsp_err=0.
- Byte store by read-modify-write: preload 0x104 with 0x11223344, then store byte 0xAA at 0x106. The word must read 0x11AA3344 and rsp_valid must rise at T+3.
- Sign and zero extension: with 0x80FF7F01 at 0x108:
  - signed byte load at 0x10A returns 0xFFFFFFFF;
  - unsigned byte load at 0x10A returns 0x000000FF;
  - signed halfword load at 0x10A returns 0xFFFF80FF.
- Errors: each of the following gives rsp_valid at T+1 with rsp_err=1, and mem_we never asserts:
  - halfword at 0x101;
  - word at 0x102;
  - size 11;
  - word at 0x4000 with MEM_BYTES=16384.
- Busy and back-to-back: hold req_valid high with different payloads during LOAD and RESP. Only the first request is serviced; the second is accepted in the cycle after RESP.
- Reset mid-RMW: assert resetn=0 during RMW_READ of a byte store to 0x10C. Expect outputs at their reset values at once, memory unchanged, no rsp_valid, and req_ready=1 after release.
